// File: rtl/dm_dmi_responder.sv
// dm_dmi_responder: Debug Module side responder for DMI requests from the DTM.
//
// Accepts one request at a time, decodes the DM register space (data, dmcontrol,
// dmstatus, hartinfo, abstractcs, command and optionally progbuf) and returns a
// registered 32-bit response with a 2-bit status. Accepted abstract commands are
// handed to the abstract-command engine as a one-cycle cmd_valid pulse.
//
// Optional feature macro: DM_PROGBUF_EN (progbuf storage and postexec support).
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   dmi_req_valid/ready, dmi_req    request channel {addr[41:34], data[33:2], op[1:0]}
//   dmi_rsp_valid/ready             response channel
//   dmi_rsp_data, dmi_rsp_op        read data, status (0 success, 2 failed)
//   hart_halted, hart_running       hart status inputs
//   hart_resumeack                  resume acknowledge pulse
//   haltreq, resumereq              hart run-control requests (levels)
//   ndmreset, dmactive              dmcontrol mirrors
//   cmd_valid, cmd                  abstract command hand-off
//   cmd_done, cmd_exc               abstract command completion / exception

module dm_dmi_responder #(
    parameter int unsigned DATA_COUNT   = 2,
    parameter int unsigned PROGBUF_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmi_req_valid,
    output logic        dmi_req_ready,
    input  logic [41:0] dmi_req,
    output logic        dmi_rsp_valid,
    input  logic        dmi_rsp_ready,
    output logic [31:0] dmi_rsp_data,
    output logic [1:0]  dmi_rsp_op,
    input  logic        hart_halted,
    input  logic        hart_running,
    input  logic        hart_resumeack,
    output logic        haltreq,
    output logic        resumereq,
    output logic        ndmreset,
    output logic        dmactive,
    output logic        cmd_valid,
    output logic [31:0] cmd,
    input  logic        cmd_done,
    input  logic        cmd_exc
);

    localparam logic [7:0] AddrData0      = 8'h04;
    localparam logic [7:0] AddrDmcontrol  = 8'h10;
    localparam logic [7:0] AddrDmstatus   = 8'h11;
    localparam logic [7:0] AddrAbstractcs = 8'h16;
    localparam logic [7:0] AddrCommand    = 8'h17;

`ifdef DM_PROGBUF_EN
    localparam logic [7:0] AddrProgbuf0   = 8'h20;
    localparam logic [4:0] PbSize         = 5'(PROGBUF_SIZE);
`else
    localparam logic [4:0] PbSize         = 5'd0;
    logic unused_cfg;
    assign unused_cfg = ^PROGBUF_SIZE;
`endif

    typedef enum logic [0:0] {StIdle, StRsp} state_t;

    state_t      state_q, state_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [1:0]  rsp_op_q, rsp_op_d;

    logic        haltreq_q, haltreq_d;
    logic        resumereq_q, resumereq_d;
    logic        ndmreset_q, ndmreset_d;
    logic        dmactive_q, dmactive_d;
    logic        resumeack_q, resumeack_d;
    logic        busy_q, busy_d;
    logic [2:0]  cmderr_q, cmderr_d;
    logic [31:0] cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [31:0] data_q [DATA_COUNT];
    logic [31:0] data_d [DATA_COUNT];
`ifdef DM_PROGBUF_EN
    logic [31:0] progbuf_q [PROGBUF_SIZE];
    logic [31:0] progbuf_d [PROGBUF_SIZE];
`endif

    logic [7:0]  req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_op;
    logic        accept;
    logic        clear_all;
    logic        cmdtype_ok;
    logic        postexec_bad;
    logic [31:0] rd_value;

    assign req_addr = dmi_req[41:34];
    assign req_data = dmi_req[33:2];
    assign req_op   = dmi_req[1:0];

    assign cmdtype_ok = (req_data[31:24] == 8'd0) || (req_data[31:24] == 8'd2);
`ifdef DM_PROGBUF_EN
    assign postexec_bad = 1'b0;
`else
    assign postexec_bad = req_data[18];
`endif

    // Read mux over pre-update state, so a request never sees its own write.
    always_comb begin
        rd_value = '0;
        case (req_addr)
            AddrDmcontrol: rd_value = {haltreq_q, 29'b0, ndmreset_q, dmactive_q};
            AddrDmstatus: begin
                rd_value[3:0] = 4'd2;
                rd_value[7]   = 1'b1;
                rd_value[8]   = hart_halted;
                rd_value[9]   = hart_halted;
                rd_value[10]  = hart_running;
                rd_value[11]  = hart_running;
                rd_value[16]  = resumeack_q;
                rd_value[17]  = resumeack_q;
            end
            AddrAbstractcs: begin
                rd_value[28:24] = PbSize;
                rd_value[12]    = busy_q;
                rd_value[10:8]  = cmderr_q;
                rd_value[3:0]   = 4'(DATA_COUNT);
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < DATA_COUNT; i++) begin
            if (req_addr == 8'(AddrData0 + i)) rd_value = data_q[i];
        end
`ifdef DM_PROGBUF_EN
        for (int unsigned i = 0; i < PROGBUF_SIZE; i++) begin
            if (req_addr == 8'(AddrProgbuf0 + i)) rd_value = progbuf_q[i];
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        rsp_data_d   = rsp_data_q;
        rsp_op_d     = rsp_op_q;
        haltreq_d    = haltreq_q;
        resumereq_d  = resumereq_q;
        ndmreset_d   = ndmreset_q;
        dmactive_d   = dmactive_q;
        resumeack_d  = resumeack_q;
        busy_d       = busy_q;
        cmderr_d     = cmderr_q;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        data_d       = data_q;
`ifdef DM_PROGBUF_EN
        progbuf_d    = progbuf_q;
`endif
        clear_all    = 1'b0;
        accept       = (state_q == StIdle) && dmi_req_valid;

        unique case (state_q)
            StIdle:  if (accept) state_d = StRsp;
            StRsp:   if (dmi_rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Completion is applied before this cycle's request so a command written
        // in the same cycle as cmd_done can still be accepted.
        if (busy_q && cmd_done) begin
            busy_d = 1'b0;
            if (cmd_exc && (cmderr_q == 3'd0)) cmderr_d = 3'd3;
        end
        if (dmactive_q && hart_resumeack) begin
            resumereq_d = 1'b0;
            resumeack_d = 1'b1;
        end

        if (accept) begin
            rsp_op_d   = (req_op == 2'b11) ? 2'd2 : 2'd0;
            rsp_data_d = (req_op == 2'b01) ? rd_value : 32'd0;
        end

        if (accept && (req_op == 2'b10)) begin
            if (req_addr == AddrDmcontrol) begin
                if (!req_data[0]) begin
                    clear_all = 1'b1;
                end else if (!dmactive_q) begin
                    // Only dmactive leaves reset; the other fields stay cleared.
                    dmactive_d = 1'b1;
                end else begin
                    haltreq_d  = req_data[31];
                    ndmreset_d = req_data[1];
                    // A resumereq write overrides a same-cycle resume ack.
                    if (req_data[30]) resumeack_d = 1'b0;
                    if (req_data[31]) begin
                        resumereq_d = 1'b0;
                    end else if (req_data[30]) begin
                        resumereq_d = 1'b1;
                    end
                end
            end else if (dmactive_q) begin
                if (req_addr == AddrAbstractcs) cmderr_d = cmderr_d & ~req_data[10:8];
                if (req_addr == AddrCommand) begin
                    if (busy_d) begin
                        if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                    end else if (cmderr_d == 3'd0) begin
                        if (!cmdtype_ok || postexec_bad) begin
                            cmderr_d = 3'd2;
                        end else if (!hart_halted) begin
                            cmderr_d = 3'd4;
                        end else begin
                            cmd_d       = req_data;
                            cmd_valid_d = 1'b1;
                            busy_d      = 1'b1;
                        end
                    end
                end
                for (int unsigned i = 0; i < DATA_COUNT; i++) begin
                    if (req_addr == 8'(AddrData0 + i)) begin
                        if (busy_d) begin
                            if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                        end else begin
                            data_d[i] = req_data;
                        end
                    end
                end
`ifdef DM_PROGBUF_EN
                for (int unsigned i = 0; i < PROGBUF_SIZE; i++) begin
                    if (req_addr == 8'(AddrProgbuf0 + i)) begin
                        if (busy_d) begin
                            if (cmderr_d == 3'd0) cmderr_d = 3'd1;
                        end else begin
                            progbuf_d[i] = req_data;
                        end
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rsp_data_q <= '0;
            rsp_op_q   <= '0;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_op_q   <= rsp_op_d;
        end
    end

    // DM state; clearing dmactive returns all of it to reset on the next cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            ndmreset_q  <= 1'b0;
            dmactive_q  <= 1'b0;
            resumeack_q <= 1'b0;
            busy_q      <= 1'b0;
            cmderr_q    <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            for (int unsigned i = 0; i < DATA_COUNT; i++) data_q[i] <= '0;
`ifdef DM_PROGBUF_EN
            for (int unsigned i = 0; i < PROGBUF_SIZE; i++) progbuf_q[i] <= '0;
`endif
        end else begin
            haltreq_q   <= haltreq_d;
            resumereq_q <= resumereq_d;
            ndmreset_q  <= ndmreset_d;
            dmactive_q  <= dmactive_d;
            resumeack_q <= resumeack_d;
            busy_q      <= busy_d;
            cmderr_q    <= cmderr_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            for (int unsigned i = 0; i < DATA_COUNT; i++) data_q[i] <= data_d[i];
`ifdef DM_PROGBUF_EN
            for (int unsigned i = 0; i < PROGBUF_SIZE; i++) progbuf_q[i] <= progbuf_d[i];
`endif
        end
    end

    assign dmi_req_ready = (state_q == StIdle);
    assign dmi_rsp_valid = (state_q == StRsp);
    assign dmi_rsp_data  = rsp_data_q;
    assign dmi_rsp_op    = rsp_op_q;
    assign haltreq       = haltreq_q;
    assign resumereq     = resumereq_q;
    assign ndmreset      = ndmreset_q;
    assign dmactive      = dmactive_q;
    assign cmd_valid     = cmd_valid_q;
    assign cmd           = cmd_q;

endmodule

// File: tb/tb_dm_dmi_responder.sv
// Testbench for dm_dmi_responder: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.

module tb_dm_dmi_responder;

    localparam int DC = 2;
    localparam int PB = 8;
`ifdef DM_PROGBUF_EN
    localparam bit PbEn = 1'b1;
    localparam logic [31:0] AbsBase = 32'h0800_0002;
`else
    localparam bit PbEn = 1'b0;
    localparam logic [31:0] AbsBase = 32'h0000_0002;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmi_req_valid = 1'b0;
    logic        dmi_req_ready;
    logic [41:0] dmi_req = '0;
    logic        dmi_rsp_valid;
    logic        dmi_rsp_ready = 1'b1;
    logic [31:0] dmi_rsp_data;
    logic [1:0]  dmi_rsp_op;
    logic        hart_halted = 1'b0;
    logic        hart_running = 1'b0;
    logic        hart_resumeack = 1'b0;
    logic        haltreq, resumereq, ndmreset, dmactive, cmd_valid;
    logic [31:0] cmd;
    logic        cmd_done = 1'b0;
    logic        cmd_exc = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    dm_dmi_responder #(
        .DATA_COUNT  (DC),
        .PROGBUF_SIZE(PB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .dmi_req_valid (dmi_req_valid),
        .dmi_req_ready (dmi_req_ready),
        .dmi_req       (dmi_req),
        .dmi_rsp_valid (dmi_rsp_valid),
        .dmi_rsp_ready (dmi_rsp_ready),
        .dmi_rsp_data  (dmi_rsp_data),
        .dmi_rsp_op    (dmi_rsp_op),
        .hart_halted   (hart_halted),
        .hart_running  (hart_running),
        .hart_resumeack(hart_resumeack),
        .haltreq       (haltreq),
        .resumereq     (resumereq),
        .ndmreset      (ndmreset),
        .dmactive      (dmactive),
        .cmd_valid     (cmd_valid),
        .cmd           (cmd),
        .cmd_done      (cmd_done),
        .cmd_exc       (cmd_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_started = 1'b0;
    bit          m_pend;
    logic [31:0] m_rsp_data;
    logic [1:0]  m_rsp_op;
    bit          m_act, m_halt, m_ndm, m_resq, m_ack, m_busy, m_cv;
    int          m_err;
    logic [31:0] m_cmd;
    logic [31:0] m_data [DC];
    logic [31:0] m_pb [PB];

    task automatic model_clear();
        m_act = 0; m_halt = 0; m_ndm = 0; m_resq = 0; m_ack = 0; m_busy = 0; m_cv = 0;
        m_err = 0; m_cmd = '0;
        for (int i = 0; i < DC; i++) m_data[i] = '0;
        for (int i = 0; i < PB; i++) m_pb[i] = '0;
    endtask

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v = 0;
        if (a >= 4 && a - 4 < DC) v = m_data[a - 4];
        else if (PbEn && a >= 32 && a - 32 < PB) v = m_pb[a - 32];
        else if (a == 16) v = (32'(m_halt) << 31) | (32'(m_ndm) << 1) | 32'(m_act);
        else if (a == 17)
            v = 32'h82 + 32'(hart_halted) * 32'h300 + 32'(hart_running) * 32'hC00
                + 32'(m_ack) * 32'h30000;
        else if (a == 22)
            v = (PbEn ? 32'(PB) << 24 : 0) + (32'(m_busy) << 12) + (32'(m_err) << 8) + 32'(DC);
        return v;
    endfunction

    task automatic busy_err();
        if (m_err == 0) m_err = 1;
    endtask

    task automatic model_write(input int a, input logic [31:0] d);
        int ctype;
        if (a == 16) begin
            if (!d[0]) model_clear();
            else if (!m_act) m_act = 1;
            else begin
                m_halt = d[31];
                m_ndm  = d[1];
                if (d[30]) m_ack = 0;
                if (d[31]) m_resq = 0;
                else if (d[30]) m_resq = 1;
            end
        end else if (m_act) begin
            if (a >= 4 && a - 4 < DC) begin
                if (m_busy) busy_err(); else m_data[a - 4] = d;
            end else if (PbEn && a >= 32 && a - 32 < PB) begin
                if (m_busy) busy_err(); else m_pb[a - 32] = d;
            end else if (a == 22) begin
                m_err = m_err & ~int'(d[10:8]);
            end else if (a == 23) begin
                ctype = int'(d[31:24]);
                if (m_busy) busy_err();
                else if (m_err != 0) ;
                else if ((ctype != 0 && ctype != 2) || (!PbEn && d[18])) m_err = 2;
                else if (!hart_halted) m_err = 4;
                else begin m_cmd = d; m_cv = 1; m_busy = 1; end
            end
        end
    endtask

    always @(posedge clk) begin
        bit hs;
        int a;
        if (rst) begin
            m_started = 1;
            m_pend = 0; m_rsp_data = '0; m_rsp_op = '0;
            model_clear();
        end else if (m_started) begin
            hs = !m_pend && dmi_req_valid;
            a = int'(dmi_req[41:34]);
            if (m_pend && dmi_rsp_ready) m_pend = 0;
            if (hs) begin
                m_pend = 1;
                m_rsp_op = (dmi_req[1:0] == 2'd3) ? 2'd2 : 2'd0;
                m_rsp_data = (dmi_req[1:0] == 2'd1) ? model_read(a) : 32'd0;
            end
            m_cv = 0;
            if (m_busy && cmd_done) begin
                m_busy = 0;
                if (cmd_exc && m_err == 0) m_err = 3;
            end
            if (m_act && hart_resumeack) begin m_resq = 0; m_ack = 1; end
            if (hs && dmi_req[1:0] == 2'd2) model_write(a, dmi_req[33:2]);
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("req_ready", 32'(dmi_req_ready), 32'(!m_pend));
            chk("rsp_valid", 32'(dmi_rsp_valid), 32'(m_pend));
            if (m_pend) begin
                chk("rsp_data", dmi_rsp_data, m_rsp_data);
                chk("rsp_op", 32'(dmi_rsp_op), 32'(m_rsp_op));
            end
            chk("haltreq", 32'(haltreq), 32'(m_halt));
            chk("resumereq", 32'(resumereq), 32'(m_resq));
            chk("ndmreset", 32'(ndmreset), 32'(m_ndm));
            chk("dmactive", 32'(dmactive), 32'(m_act));
            chk("cmd_valid", 32'(cmd_valid), 32'(m_cv));
            chk("cmd", cmd, m_cmd);
        end
    end

    // ---------------- directed helpers ----------------
    logic cv_seen;

    task automatic dmi_txn(input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic [1:0] rop);
        int n = 0;
        dmi_req = {addr, wdata, op};
        dmi_req_valid = 1'b1;
        dmi_rsp_ready = 1'b1;
        @(negedge clk);
        while (!dmi_req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #2 dmi_req_valid = 1'b0;
        @(negedge clk);
        while (!dmi_rsp_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 50) chk("txn_timeout", 32'(n), 32'd0);
        rdata = dmi_rsp_data;
        rop = dmi_rsp_op;
        cv_seen = cmd_valid;
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] d);
        logic [31:0] r;
        logic [1:0] o;
        dmi_txn(2'b10, addr, d, r, o);
    endtask

    task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] r;
        logic [1:0] o;
        dmi_txn(2'b01, addr, 32'h0, r, o);
        chk(name, r, exp);
        chk({name, "_op"}, 32'(o), 32'd0);
    endtask

    task automatic pulse_done(input logic exc);
        cmd_done = 1'b1;
        cmd_exc = exc;
        @(posedge clk);
        #2 cmd_done = 1'b0;
        cmd_exc = 1'b0;
    endtask

    function automatic logic [41:0] rand_req();
        logic [7:0]  a;
        logic [31:0] d;
        logic [1:0]  op;
        int r;
        case ($urandom_range(0, 10))
            0: a = 8'h04;
            1: a = 8'h05;
            2: a = 8'h10;
            3: a = 8'h11;
            4: a = 8'h16;
            5: a = 8'h17;
            6: a = 8'h20;
            7: a = 8'h27;
            8: a = 8'h12;
            9: a = 8'h3c;
            default: a = 8'h17;
        endcase
        d = $urandom();
        if (a == 8'h10) d[0] = ($urandom_range(0, 15) != 0);
        if (a == 8'h17) d[31:24] = 8'($urandom_range(0, 3));
        r = $urandom_range(0, 9);
        op = (r == 0) ? 2'd0 : (r <= 4) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
        return {a, d, op};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [1:0]  o;

        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(dmi_req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(dmi_rsp_valid), 32'd0);
        chk("rst_rsp_data", dmi_rsp_data, 32'd0);
        chk("rst_rsp_op", 32'(dmi_rsp_op), 32'd0);
        chk("rst_outs", {26'd0, haltreq, resumereq, ndmreset, dmactive, cmd_valid, 1'b0}, 32'd0);
        chk("rst_cmd", cmd, 32'd0);
        @(posedge clk);
        #2;

        // Reset and activate
        rd_chk("dmstatus_reset", 8'h11, 32'h0000_0082);
        wr(8'h10, 32'h1);
        wr(8'h04, 32'hDEAD_BEEF);
        rd_chk("data0_rb", 8'h04, 32'hDEAD_BEEF);
        wr(8'h06, 32'h1111_2222);
        rd_chk("data2_unimpl", 8'h06, 32'h0);

        // Halt and resume
        wr(8'h10, 32'h8000_0001);
        chk("haltreq_set", 32'(haltreq), 32'd1);
        hart_halted = 1'b1;
        wr(8'h10, 32'h4000_0001);
        chk("resumereq_set", 32'(resumereq), 32'd1);
        chk("haltreq_clr", 32'(haltreq), 32'd0);
        hart_resumeack = 1'b1;
        @(posedge clk);
        #2 hart_resumeack = 1'b0;
        chk("resumereq_ack", 32'(resumereq), 32'd0);
        rd_chk("dmstatus_ack", 8'h11, 32'h0003_0382);

        // Command while busy
        wr(8'h17, 32'h0022_1001);
        chk("cmd_valid_pulse", 32'(cv_seen), 32'd1);
        chk("cmd_capture", cmd, 32'h0022_1001);
        rd_chk("abs_busy", 8'h16, AbsBase | 32'h1000);
        wr(8'h04, 32'h1234_5678);
        rd_chk("abs_busy_err", 8'h16, AbsBase | 32'h1100);
        rd_chk("data0_kept", 8'h04, 32'hDEAD_BEEF);
        pulse_done(1'b0);
        rd_chk("abs_done", 8'h16, AbsBase | 32'h0100);
        wr(8'h16, 32'h700);
        rd_chk("abs_clr", 8'h16, AbsBase);

        // Error cases
        wr(8'h17, 32'h0100_0000);
        rd_chk("err_cmdtype", 8'h16, AbsBase | 32'h0200);
        wr(8'h16, 32'h700);
        hart_halted = 1'b0;
        wr(8'h17, 32'h0022_1001);
        rd_chk("err_halt", 8'h16, AbsBase | 32'h0400);
        wr(8'h16, 32'h700);
        hart_halted = 1'b1;
        wr(8'h17, 32'h0022_1001);
        pulse_done(1'b1);
        rd_chk("err_exc", 8'h16, AbsBase | 32'h0300);
        wr(8'h16, 32'h700);

        // Backpressure
        dmi_req = {8'h04, 32'h0, 2'b01};
        dmi_req_valid = 1'b1;
        dmi_rsp_ready = 1'b0;
        @(posedge clk);
        #2 dmi_req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'(dmi_rsp_valid), 32'd1);
            chk("bp_data", dmi_rsp_data, 32'hDEAD_BEEF);
            chk("bp_ready", 32'(dmi_req_ready), 32'd0);
        end
        @(posedge clk);
        #2 dmi_rsp_ready = 1'b1;
        @(posedge clk);
        #2;

        // Reserved op has no side effects
        dmi_txn(2'b11, 8'h04, 32'hFFFF_FFFF, r, o);
        chk("op3_op", 32'(o), 32'd2);
        chk("op3_data", r, 32'd0);
        rd_chk("op3_noeffect", 8'h04, 32'hDEAD_BEEF);

        // Configuration
        if (PbEn) begin
            wr(8'h27, 32'hA5A5_0007);
            rd_chk("pb7_rb", 8'h27, 32'hA5A5_0007);
            wr(8'h17, 32'h0026_1001);
            rd_chk("pb_postexec_ok", 8'h16, AbsBase | 32'h1000);
            pulse_done(1'b0);
        end else begin
            wr(8'h20, 32'hA5A5_0000);
            rd_chk("pb0_unimpl", 8'h20, 32'h0);
            wr(8'h17, 32'h0026_1001);
            rd_chk("postexec_err", 8'h16, AbsBase | 32'h0200);
            wr(8'h16, 32'h700);
        end

        // Deactivation clears state and blocks writes
        wr(8'h10, 32'h0);
        rd_chk("deact_data0", 8'h04, 32'h0);
        wr(8'h04, 32'h5555_AAAA);
        rd_chk("deact_wr_ignored", 8'h04, 32'h0);
        wr(8'h10, 32'h1);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 499) == 0);
            dmi_req_valid  = ($urandom_range(0, 2) != 0);
            dmi_rsp_ready  = ($urandom_range(0, 3) != 0);
            dmi_req        = rand_req();
            hart_halted    = ($urandom_range(0, 7) != 0);
            hart_running   = $urandom_range(0, 1) == 1;
            hart_resumeack = ($urandom_range(0, 15) == 0);
            cmd_done       = ($urandom_range(0, 5) == 0);
            cmd_exc        = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        dmi_req_valid = 1'b0;
        hart_resumeack = 1'b0;
        cmd_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_dmi_responder.md
# dm_dmi_responder

Debug Module–side responder for DMI transactions issued by the DTM. It accepts one `dmi_t` request at a time, decodes the DM CSR address space and returns a 32-bit read-data/status response. It implements:

- the data and progbuf register files;
- dmcontrol, dmstatus and hartinfo;
- abstractcs/command, with busy and cmderr tracking.

Accepted abstract commands are handed to the abstract-command engine. The block sits between the DTM's DMI port and the DM's hart control and abstract-command logic.

## Interface

Parameters:
- `DATA_COUNT`, 2: number of implemented data registers (data0..DATA_COUNT-1), range 1..12.
- `PROGBUF_SIZE`, 8: number of implemented progbuf words, range 1..16. Used only with `DM_PROGBUF_EN`.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst` in 1: synchronous, active-high reset.
- `dmi_req_valid` in 1: request valid.
- `dmi_req_ready` out 1: request accepted when high together with valid.
- `dmi_req` in 42: `dmi_t` fields {addr[41:34], data[33:2], op[1:0]}.
- `dmi_rsp_valid` out 1: response valid.
- `dmi_rsp_ready` in 1: DTM consumes the response.
- `dmi_rsp_data` out 32: read data.
- `dmi_rsp_op` out 2: 0 = success, 2 = failed.
- `hart_halted` in 1: hart halted status.
- `hart_running` in 1: hart running status.
- `hart_resumeack` in 1: resume acknowledge pulse.
- `haltreq` out 1: halt request, level.
- `resumereq` out 1: resume request, level.
- `ndmreset` out 1: mirror of dmcontrol.ndmreset.
- `dmactive` out 1: mirror of dmcontrol.dmactive.
- `cmd_valid` out 1: single-cycle pulse; the engine must sample the command in that cycle.
- `cmd` out 32: captured `command_t`.
- `cmd_done` in 1: abstract command completed.
- `cmd_exc` in 1: qualifies `cmd_done` as completed with exception.

## Operation

State machine:
- IDLE (`dmi_req_ready`=1) goes to RSP on handshake.
- RSP (`dmi_rsp_valid`=1) goes back to IDLE when `dmi_rsp_ready`=1.
- Only one request is outstanding at a time; the response fields are registered.

Request ops:
- op 00 (nop): data 0, op 0.
- op 01 (read): data is the register value, op 0.
- op 10 (write): data 0, op 0.
- op 11: no side effects, data 0, op 2.

Reads:
- Unimplemented addresses, including data/progbuf indices at or above the configured count, read 0.
- Writes to unimplemented addresses are ignored.

dmactive:
- While dmactive=0, every register except dmcontrol.dmactive is held at its reset value, and writes to other addresses are ignored.
- A dmcontrol write that clears dmactive resets all DM state on the next cycle.

dmcontrol:
- haltreq and ndmreset are stored as written.
- A write with resumereq=1 sets `resumereq`; it clears on `hart_resumeack` or on a later write with haltreq=1.
- If haltreq and resumereq are both written as 1, haltreq wins and resumereq is not set.
- All other fields read 0.

dmstatus (read-only):
- version=2, authenticated=1.
- allhalted/anyhalted = `hart_halted`; allrunning/anyrunning = `hart_running`.
- allresumeack/anyresumeack are sticky. They are set by `hart_resumeack` and cleared by a dmcontrol write with resumereq=1.

hartinfo reads 0.

abstractcs:
- datacount=DATA_COUNT.
- progbufsize = PROGBUF_SIZE, or 0 when `DM_PROGBUF_EN` is off.
- busy and cmderr are as below; cmderr is write-1-to-clear per bit.

Command write, checked in this order:
1. busy=1: cmderr=1 if cmderr was 0; the write is ignored.
2. cmderr≠0: ignored.
3. cmdtype∉{0,2}, or an unsupported postexec: cmderr=2.
4. `hart_halted`=0: cmderr=4.
5. Otherwise: capture into `cmd`, pulse `cmd_valid`, set busy=1.

Busy and completion:
- While busy=1, writes to data or progbuf set cmderr=1 (if it was 0) and are dropped. Reads of data and progbuf are allowed.
- `cmd_done` clears busy. If `cmd_exc`=1, cmderr is set to 3 (only when cmderr was 0).
- `cmd_done` while not busy is ignored.

## Timing

Reset values:
- `dmi_req_ready`=1; `dmi_rsp_valid`=0.
- `dmi_rsp_data`=0; `dmi_rsp_op`=0.
- `haltreq`, `resumereq`, `ndmreset`, `dmactive`, `cmd_valid` = 0; `cmd`=0.
- All registers 0.

Latency:
- Handshake at cycle T gives register update and `cmd_valid` at T+1, and `dmi_rsp_valid`=1 at T+1.
- The response is held stable until `dmi_rsp_ready`. The earliest next accept is the cycle after the response handshake.
- Read data reflects state before the same request's write. A write never affects its own response.

Simultaneous events and reset:
- `cmd_done` in the same cycle as an accepted command write is processed first, so the new command can be accepted.
- `hart_resumeack` in the same cycle as a resumereq write: the write wins, so `resumereq`=1 and ack is cleared.
- `rst` mid-transaction drops any pending response. `dmi_rsp_valid`=0 the next cycle.

## Configuration

`DM_PROGBUF_EN`:
- Defined: progbuf0..PROGBUF_SIZE-1 (0x20+) are read/write registers, progbufsize=PROGBUF_SIZE, and postexec=1 commands are accepted.
- Undefined: no progbuf storage, progbuf reads 0 and writes are ignored, progbufsize=0, and any command with postexec=1 gives cmderr=2.

## Test plan

- **Reset and activate:** reset, read dmstatus → 0x0000_0082 with hart neither halted nor running. Write dmcontrol=1, then write data0=0xDEADBEEF and read it back → 0xDEADBEEF, op 0.
- **Halt and resume:** write dmcontrol haltreq=1 → `haltreq`=1 at T+1. Assert `hart_halted`, then write dmcontrol resumereq=1 → `resumereq`=1. Pulse ack → `resumereq`=0, dmstatus allresumeack=1.
- **Command while busy:** with `hart_halted`, write command 0x0022_1001 → `cmd_valid` pulse, abstractcs busy=1. Write data0 → cmderr=1 and data0 unchanged. Pulse `cmd_done` → busy=0. Write abstractcs 0x700 → cmderr=0.
- **Error cases:** cmdtype=1 → cmderr=2. A valid command with `hart_halted`=0 → cmderr=4. `cmd_done`+`cmd_exc` → cmderr=3.
- **Backpressure and reserved op:** hold `dmi_rsp_ready`=0 for 5 cycles → response stable and `dmi_req_ready`=0. Op 11 → `dmi_rsp_op`=2.
- **Config check:** with `DM_PROGBUF_EN`, progbuf7 read/write works and abstractcs[28:24]=8. Without it, progbuf0 reads 0 and postexec gives cmderr=2.
